// File: rtl/mem_if_pkg.sv
// Shared memory-interface types for the line refill path and the cache.
// Holds the refill FSM encoding and line-geometry helpers.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } refill_state_t;

  localparam int unsigned WORD_BYTES = 4;

  function automatic int unsigned words_per_line(
    input int unsigned obits
  );
    return (32'd1 << obits) / WORD_BYTES;
  endfunction

  // Clears the byte-offset bits of an address.
  function automatic logic [31:0] line_base(
    input logic [31:0] addr,
    input int unsigned obits
  );
    return addr & ~((32'd1 << obits) - 32'd1);
  endfunction

endpackage

// File: rtl/line_refill_unit.sv
// Line refill unit: assembles a cache line from 32-bit memory words.
// Ports: clk_i/rstn_i; cache req_en_i/req_addr_i -> line_valid_o/line_data_o;
//        refill_busy_o; memory mem_req_o/mem_addr_o <- mem_ack_i/mem_rdata_i.
module line_refill_unit
  import mem_if_pkg::*;
#(
  parameter  int unsigned ByteOffsetBits = 5,
  localparam int unsigned NrWordsPerLine = words_per_line(ByteOffsetBits),
  localparam int unsigned LineSize       = 32 * NrWordsPerLine
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_en_i,
  input  logic [31:0]         req_addr_i,
  output logic                line_valid_o,
  output logic [LineSize-1:0] line_data_o,
  output logic                refill_busy_o,
  output logic                mem_req_o,
  output logic [31:0]         mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_rdata_i
);

  localparam int unsigned CntW = $clog2(NrWordsPerLine);
  localparam logic [CntW-1:0] LastCnt = CntW'(NrWordsPerLine - 1);

  refill_state_t state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          stale_q, stale_d;
  logic [NrWordsPerLine-1:0][31:0] buf_q, buf_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    stale_d = stale_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (req_en_i) begin
          state_d = REQ;
          base_d  = line_base(req_addr_i, ByteOffsetBits);
          cnt_d   = '0;
          stale_d = 1'b0;
        end
      end
      REQ: begin
        // A dropped request only marks the line stale; the
        // memory request is never retracted before its ack.
        if (!req_en_i) stale_d = 1'b1;
        if (mem_ack_i) begin
          buf_d[cnt_q] = mem_rdata_i;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      stale_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
      buf_q   <= buf_d;
    end
  end

  assign mem_req_o     = (state_q == REQ);
  assign mem_addr_o    = base_q
                       + {{(30-CntW){1'b0}}, cnt_q, 2'b00};
  assign refill_busy_o = (state_q != IDLE);
  assign line_data_o   = buf_q;

  // Address is compared live so a cache that moved on during
  // DONE gets no pulse; req_en_i is deliberately not used here.
  assign line_valid_o = (state_q == DONE) && !stale_q
    && (line_base(req_addr_i, ByteOffsetBits) == base_q);

endmodule

// File: tb/tb_line_refill_unit.sv
// Directed self-checking bench for line_refill_unit.
// Covers reset, zero-wait, wait states, abort, address change, mid-fill reset.
module tb_line_refill_unit;

  localparam logic [31:0] MASK = 32'hA5A5A5A5;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_en;
  logic [31:0]  req_addr;
  logic         line_valid;
  logic [255:0] line_data;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  logic         rand_mode;
  logic         rnd_ack;
  logic [31:0]  rnd_data;
  int           wait_tgt = 0;
  int           wc;
  int           ack_cnt = 0;
  int           a0;
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  line_refill_unit dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .req_en_i      (req_en),
    .req_addr_i    (req_addr),
    .line_valid_o  (line_valid),
    .line_data_o   (line_data),
    .refill_busy_o (busy),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata)
  );

  // Memory model: ack after wait_tgt wait cycles per word.
  assign mem_ack = rand_mode ? rnd_ack
                 : (mem_req && (wc == wait_tgt));
  assign mem_rdata = rand_mode ? rnd_data : (mem_addr ^ MASK);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) wc <= 0;
    else if (mem_req && !mem_ack) wc <= wc + 1;
    else wc <= 0;
  end

  always @(posedge clk) begin
    if (rstn && mem_req && mem_ack) ack_cnt <= ack_cnt + 1;
  end

  function automatic logic [255:0] exp_line(input logic [31:0] b);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = (b + 32'(4*k)) ^ MASK;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max);
    int n;
    n = 0;
    while (!mem_req && n < max) begin
      tick();
      n++;
    end
    chk("req_start", mem_req, 1);
  endtask

  initial begin
    // Reset with random inputs
    rand_mode = 1'b1;
    rstn      = 1'b0;
    req_en    = 1'($urandom);
    req_addr  = $urandom;
    rnd_ack   = 1'($urandom);
    rnd_data  = $urandom;
    #1;
    chk("rst_valid", line_valid, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", line_data, 0);
    tick();
    tick();
    chk("rst_hold_req", mem_req, 0);
    chk("rst_hold_busy", busy, 0);
    rand_mode = 1'b0;
    req_en    = 1'b0;
    req_addr  = '0;
    rstn      = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Zero-wait refill
    req_addr = 32'h1234;
    req_en   = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("zw_req", mem_req, 1);
      chk("zw_addr", mem_addr, 32'h1220 + 32'(4*(c-1)));
      chk("zw_novalid", line_valid, 0);
    end
    tick();
    chk("zw_valid", line_valid, 1);
    chk("zw_data", line_data, exp_line(32'h1220));
    req_en = 1'b0;
    #1;
    chk("zw_valid_no_req_path", line_valid, 1);
    tick();
    chk("zw_valid_once", line_valid, 0);
    chk("zw_idle", busy, 0);

    // Wait states: ack on 4th cycle of each word
    wait_tgt = 3;
    req_en   = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      chk("ws_busy", busy, 1);
      chk("ws_req", mem_req, 1);
      chk("ws_addr", mem_addr, 32'h1220 + 32'(4*((c-1)/4)));
      chk("ws_novalid", line_valid, 0);
    end
    tick();
    chk("ws_busy33", busy, 1);
    chk("ws_valid", line_valid, 1);
    chk("ws_data", line_data, exp_line(32'h1220));
    req_en = 1'b0;
    tick();
    chk("ws_idle", busy, 0);
    wait_tgt = 0;

    // Abort: request dropped in cycle 4
    a0     = ack_cnt;
    req_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("ab_req", mem_req, 1);
    end
    tick();
    req_en = 1'b0;
    chk("ab_req4", mem_req, 1);
    for (int c = 5; c <= 8; c++) begin
      tick();
      chk("ab_req_kept", mem_req, 1);
    end
    tick();
    chk("ab_novalid", line_valid, 0);
    chk("ab_done_busy", busy, 1);
    chk("ab_acks", 32'(ack_cnt - a0), 8);
    tick();
    chk("ab_idle", busy, 0);
    tick();
    tick();
    req_en = 1'b1;
    tick();
    chk("ab_new_req", mem_req, 1);
    chk("ab_new_addr", mem_addr, 32'h1220);
    for (int c = 14; c <= 20; c++) tick();
    tick();
    chk("ab_new_valid", line_valid, 1);
    chk("ab_new_data", line_data, exp_line(32'h1220));
    req_en = 1'b0;
    tick();

    // Address change during DONE
    req_addr = 32'h1234;
    req_en   = 1'b1;
    for (int c = 1; c <= 8; c++) tick();
    tick();
    req_addr = 32'h2000;
    #1;
    chk("ac_busy", busy, 1);
    chk("ac_novalid", line_valid, 0);
    wait_req(4);
    chk("ac_addr", mem_addr, 32'h2000);
    for (int c = 1; c <= 7; c++) tick();
    tick();
    chk("ac_valid", line_valid, 1);
    chk("ac_data", line_data, exp_line(32'h2000));
    req_en = 1'b0;
    tick();

    // Reset mid-fill after word 5 ack
    req_addr = 32'h1234;
    req_en   = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    tick();
    chk("mr_addr_w6", mem_addr, 32'h1238);
    rstn = 1'b0;
    #1;
    chk("mr_req", mem_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_data", line_data, 0);
    chk("mr_valid", line_valid, 0);
    tick();
    chk("mr_hold", mem_req, 0);
    rstn = 1'b1;
    wait_req(4);
    chk("mr_refetch_addr", mem_addr, 32'h1220);
    for (int c = 1; c <= 7; c++) tick();
    tick();
    chk("mr_valid_after", line_valid, 1);
    chk("mr_data_after", line_data, exp_line(32'h1220));
    req_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
